// File: rtl/gf180mcu_fd_sc_mcu7t5v0__oai32_selftest.sv
// Exhaustive self-test sequencer for the oai32 cell: walks all 32 input vectors, checks ZN, counts mismatches.
// Optional first-failure log built only when GF180MCU_FD_SC_MCU7T5V0__OAI32_SELFTEST_FAILLOG_EN is defined.
module gf180mcu_fd_sc_mcu7t5v0__oai32_selftest #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             A1,
  output logic             A2,
  output logic             A3,
  output logic             B1,
  output logic             B2,
  input  logic             ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [4:0]       FAIL_VEC
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CAPTURE, S_DONE} state_t;

  localparam logic [3:0] LP_SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [4:0]       r_v;
  logic [3:0]       r_cnt;
  logic [ERR_W-1:0] r_err;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_exp;
  logic             w_mis;
  logic             w_start_ok;
  logic [ERR_W-1:0] w_err_next;

  assign w_exp      = ~((|r_v[2:0]) & (|r_v[4:3]));
  assign w_mis      = (r_state == S_CAPTURE) && (ZN != w_exp);
  assign w_start_ok = START && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Saturate rather than wrap so a narrow counter never reports a false pass.
  assign w_err_next = (w_mis && !(&r_err)) ? r_err + ERR_W'(1) : r_err;

  // NOTE: r_v doubles as the pin register; it returns to 0 outside a run so pins idle low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_v     <= '0;
      r_cnt   <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (START) begin
            r_state <= S_DRIVE;
            r_v     <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (r_cnt == LP_SETTLE_LAST) begin
            r_state <= S_CAPTURE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_CAPTURE: begin
          r_err <= w_err_next;
          if (r_v == 5'd31) begin
            r_state <= S_DONE;
            r_v     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_state <= S_DRIVE;
            r_v     <= r_v + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI32_SELFTEST_FAILLOG_EN
  logic       r_fail_valid;
  logic [4:0] r_fail_vec;

  // The first mismatch of a run wins; later ones leave the record alone.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_start_ok) begin
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else if (w_mis && !r_fail_valid) begin
      r_fail_valid <= 1'b1;
      r_fail_vec   <= r_v;
    end
  end

  assign FAIL_VALID = r_fail_valid;
  assign FAIL_VEC   = r_fail_vec;
`else
  logic w_unused;
  assign w_unused   = w_start_ok;
  assign FAIL_VALID = 1'b0;
  assign FAIL_VEC   = '0;
`endif

  assign A1      = r_v[0];
  assign A2      = r_v[1];
  assign A3      = r_v[2];
  assign B1      = r_v[3];
  assign B2      = r_v[4];
  assign BUSY    = r_busy;
  assign DONE    = r_done;
  assign PASS    = r_pass;
  assign ERR_CNT = r_err;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__oai32_selftest.sv
// Scoreboard bench for the oai32 self-test sequencer: stimulus pushes expected run results, monitors pop on DONE.
module tb_gf180mcu_fd_sc_mcu7t5v0__oai32_selftest;

`ifdef GF180MCU_FD_SC_MCU7T5V0__OAI32_SELFTEST_FAILLOG_EN
  localparam bit FAILLOG = 1'b1;
`else
  localparam bit FAILLOG = 1'b0;
`endif

  typedef struct {
    int done_edge;
    int err;
    bit pass;
    bit fv;
    int fvec;
  } exp_t;

  exp_t q[$];
  exp_t q3[$];

  logic CLK, RST, START, START3;
  logic A1, A2, A3, B1, B2, ZN, BUSY, DONE, PASS, FAIL_VALID;
  logic [5:0] ERR_CNT;
  logic [4:0] FAIL_VEC;
  logic C1, C2, C3, D1, D2, ZN3, BUSY3, DONE3, PASS3, FAIL_VALID3;
  logic [2:0] ERR_CNT3;
  logic [4:0] FAIL_VEC3;

  int zn_mode;  // 0 real cell, 1 stuck-at-0, 2 stuck-at-1
  int cyc;
  int checks;
  int errors;
  logic done_q, done3_q;
  logic zn_ref, zn_ref3;

  assign zn_ref  = ~((A1 | A2 | A3) & (B1 | B2));
  assign zn_ref3 = ~((C1 | C2 | C3) & (D1 | D2));
  assign ZN  = (zn_mode == 0) ? zn_ref : (zn_mode == 1) ? 1'b0 : 1'b1;
  assign ZN3 = ~zn_ref3;

  gf180mcu_fd_sc_mcu7t5v0__oai32_selftest dut (
    .CLK(CLK), .RST(RST), .START(START),
    .A1(A1), .A2(A2), .A3(A3), .B1(B1), .B2(B2), .ZN(ZN),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
    .FAIL_VALID(FAIL_VALID), .FAIL_VEC(FAIL_VEC)
  );

  gf180mcu_fd_sc_mcu7t5v0__oai32_selftest #(.SETTLE_CYCLES(1), .ERR_W(3)) dut3 (
    .CLK(CLK), .RST(RST), .START(START3),
    .A1(C1), .A2(C2), .A3(C3), .B1(D1), .B2(D2), .ZN(ZN3),
    .BUSY(BUSY3), .DONE(DONE3), .PASS(PASS3), .ERR_CNT(ERR_CNT3),
    .FAIL_VALID(FAIL_VALID3), .FAIL_VEC(FAIL_VEC3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for the default-parameter instance.
  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1 && done_q !== 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("done_edge", cyc, e.done_edge);
        check("busy_at_done", BUSY, 0);
        check("err_cnt", ERR_CNT, e.err);
        check("pass", PASS, e.pass);
        check("fail_valid", FAIL_VALID, e.fv);
        check("fail_vec", FAIL_VEC, e.fvec);
        check("pins_idle", {B2, B1, A3, A2, A1}, 0);
      end
    end
    done_q = DONE;
  end

  // Monitor for the narrow-counter instance.
  always @(negedge CLK) begin
    exp_t e;
    if (DONE3 === 1'b1 && done3_q !== 1'b1) begin
      if (q3.size() == 0) begin
        check("unexpected_done3", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        check("done3_edge", cyc, e.done_edge);
        check("err_cnt3", ERR_CNT3, e.err);
        check("pass3", PASS3, e.pass);
        check("fail_valid3", FAIL_VALID3, e.fv);
        check("fail_vec3", FAIL_VEC3, e.fvec);
      end
    end
    done3_q = DONE3;
  end

  // Pulse START for one edge; returns the number of the edge that sampled it.
  task automatic start_run(input int mode, input int err, input bit pass,
                           input bit fv, input int fvec, output int s);
    exp_t e;
    zn_mode = mode;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    s = cyc;
    e.done_edge = s + 96;
    e.err       = err;
    e.pass      = pass;
    e.fv        = fv & FAILLOG;
    e.fvec      = FAILLOG ? fvec : 0;
    q.push_back(e);
    check("busy_after_start", BUSY, 1);
    check("done_after_start", DONE, 0);
    check("pins_after_start", {B2, B1, A3, A2, A1}, 0);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || q3.size() != 0) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0 || q3.size() != 0) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      q.delete();
      q3.delete();
    end
  endtask

  initial begin
    int s;
    exp_t e;
    checks  = 0;
    errors  = 0;
    zn_mode = 0;
    done_q  = 1'b0;
    done3_q = 1'b0;
    RST     = 1'b1;
    START   = 1'b0;
    START3  = 1'b0;
    #12;
    check("rst_outputs", {BUSY, DONE, PASS, FAIL_VALID, FAIL_VEC, ERR_CNT, B2, B1, A3, A2, A1}, 0);
    check("rst_outputs3", {BUSY3, DONE3, PASS3, FAIL_VALID3, FAIL_VEC3, ERR_CNT3}, 0);
    @(negedge CLK);
    RST = 1'b0;

    // Real cell: walk every vector and confirm the pin mapping as each one is applied.
    start_run(0, 0, 1'b1, 1'b0, 0, s);
    for (int k = 0; k < 32; k++) begin
      check($sformatf("pins_v%0d", k), {B2, B1, A3, A2, A1}, k);
      check($sformatf("busy_v%0d", k), BUSY, 1);
      repeat (3) @(negedge CLK);
    end
    wait_empty("real");

    // Stuck-at-0: the 11 vectors with EXP=1 mismatch, first at V=0.
    start_run(1, 11, 1'b0, 1'b1, 0, s);
    wait_empty("stuck0");

    // Stuck-at-1: the 21 vectors with EXP=0 mismatch, first at V=9.
    start_run(2, 21, 1'b0, 1'b1, 9, s);
    wait_empty("stuck1");

    // START while busy is ignored.
    start_run(0, 0, 1'b1, 1'b0, 0, s);
    repeat (39) @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    check("busy_ignore_start", BUSY, 1);
    check("pins_ignore_start", {B2, B1, A3, A2, A1}, 13);
    wait_empty("busy_restart");

    // START from DONE restarts immediately.
    check("done_level_held", DONE, 1);
    start_run(0, 0, 1'b1, 1'b0, 0, s);
    wait_empty("done_restart");

    // Asynchronous reset mid-cycle while V=10.
    start_run(0, 0, 1'b1, 1'b0, 0, s);
    repeat (31) @(negedge CLK);
    check("pins_before_rst", {B2, B1, A3, A2, A1}, 10);
    #1 RST = 1'b1;
    #1;
    check("midrun_rst_outputs", {BUSY, DONE, PASS, FAIL_VALID, FAIL_VEC, ERR_CNT, B2, B1, A3, A2, A1}, 0);
    q.delete();
    @(negedge CLK);
    RST = 1'b0;
    start_run(0, 0, 1'b1, 1'b0, 0, s);
    wait_empty("after_rst");

    // Narrow counter with inverted ZN: 32 mismatches saturate at 7; one-cycle settle ends at edge 64.
    @(negedge CLK);
    START3 = 1'b1;
    @(negedge CLK);
    START3 = 1'b0;
    s = cyc;
    e.done_edge = s + 64;
    e.err       = 7;
    e.pass      = 1'b0;
    e.fv        = FAILLOG;
    e.fvec      = 0;
    q3.push_back(e);
    check("busy3_after_start", BUSY3, 1);
    wait_empty("sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
